// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller (one word per line).
// Optional hit/miss statistics counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int INDEX_W = 4,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              hit
`ifdef CACHE_CTRL_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE_MEM, RESP} state_t;

    state_t             state;
    logic [DATA_W-1:0]  data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid_r;
    logic [ADDR_W-1:0]  addr_r;
    logic               we_r;
    logic [DATA_W-1:0]  wdata_r;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;

    assign idx     = addr_r[INDEX_W-1:0];
    assign tag     = addr_r[ADDR_W-1:INDEX_W];
    assign cpu_idx = cpu_addr[INDEX_W-1:0];
    assign cpu_tag = cpu_addr[ADDR_W-1:INDEX_W];

    // Control FSM; the hit flag is evaluated while accepting the request so it is a register during LOOKUP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            valid_r   <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hit       <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            hit     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        state <= LOOKUP;
                        hit   <= valid_r[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
                    end
                end
                LOOKUP: begin
                    if (we_r) begin
                        state     <= WRITE_MEM;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_r;
                        mem_wdata <= wdata_r;
                    end else if (hit) begin
                        state     <= RESP;
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= data_mem[idx];
                    end else begin
                        state    <= REFILL;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= addr_r;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        state        <= RESP;
                        mem_req      <= 1'b0;
                        valid_r[idx] <= 1'b1;
                        cpu_rdata    <= mem_rdata;
                        cpu_ack      <= 1'b1;
                    end
                end
                WRITE_MEM: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        cpu_ack <= 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request latch and line storage; array writes are suppressed under reset so an abandoned refill leaves no trace.
    always_ff @(posedge clk) begin
        if (state == IDLE && cpu_req) begin
            addr_r  <= cpu_addr;
            we_r    <= cpu_we;
            wdata_r <= cpu_wdata;
        end
        if (!reset) begin
            if (state == LOOKUP && we_r && hit)
                data_mem[idx] <= wdata_r;
            if (state == REFILL && mem_ack) begin
                data_mem[idx] <= mem_rdata;
                tag_mem[idx]  <= tag;
            end
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit)
                hit_count <= sat_inc(hit_count);
            else
                miss_count <= sat_inc(miss_count);
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl; a small inline memory responder answers mem_req.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        hit;
`ifdef CACHE_CTRL_STATS_EN
    logic        stats_clr;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int total = 0;
    int bad   = 0;

    cache_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .hit       (hit)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .stats_clr (stats_clr),
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete CPU transaction, acting as memory with the given wait count and refill data.
    task automatic access(input string name, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int waits, input logic [15:0] mdata,
                          input logic exp_hit, input logic [15:0] exp_rdata);
        int   n;
        int   wcnt;
        logic mem_seen;
        logic got_ack;
        logic exp_mem;
        exp_mem   = we || !exp_hit;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        tick;
        n = 1;
        chk({name, ":hit"}, 32'(hit), 32'(exp_hit));
        chk({name, ":lookup_quiet"}, {30'd0, mem_req, cpu_ack}, 32'd0);
        mem_seen = 1'b0;
        got_ack  = 1'b0;
        wcnt     = 0;
        while (!got_ack && n < 40) begin
            tick;
            n++;
            mem_ack = 1'b0;
            if (cpu_ack) begin
                got_ack = 1'b1;
            end else if (mem_req) begin
                if (!mem_seen) begin
                    mem_seen = 1'b1;
                    chk({name, ":mem_addr"}, 32'(mem_addr), 32'(addr));
                    chk({name, ":mem_we"}, 32'(mem_we), 32'(we));
                    if (we) chk({name, ":mem_wdata"}, 32'(mem_wdata), 32'(wdata));
                end
                if (wcnt == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mdata;
                end
                wcnt++;
            end
        end
        mem_ack = 1'b0;
        chk({name, ":ack_seen"}, 32'(got_ack), 32'd1);
        chk({name, ":latency"}, 32'(n), exp_mem ? 32'(3 + waits) : 32'd2);
        chk({name, ":mem_used"}, 32'(mem_seen), 32'(exp_mem));
        chk({name, ":mem_req_low_at_ack"}, 32'(mem_req), 32'd0);
        if (!we) chk({name, ":rdata"}, 32'(cpu_rdata), 32'(exp_rdata));
        tick;
        cpu_req = 1'b0;
        chk({name, ":ack_pulse"}, 32'(cpu_ack), 32'd0);
        tick;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
`ifdef CACHE_CTRL_STATS_EN
        stats_clr = 1'b0;
`endif
        tick;
        tick;
        chk("rst:outs", {26'd0, cpu_ack, mem_req, mem_we, hit, 2'b00}, 32'd0);
        chk("rst:cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst:mem_addr", 32'(mem_addr), 32'd0);
        chk("rst:mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst:valid", 32'(dut.valid_r), 32'd0);
`ifdef CACHE_CTRL_STATS_EN
        chk("rst:counts", {hit_count, miss_count}, 32'd0);
`endif
        reset = 1'b0;
        tick;

        access("rd_miss_0123", 1'b0, 16'h0123, 16'h0000, 2, 16'hBEEF, 1'b0, 16'hBEEF);
        chk("valid3_set", 32'(dut.valid_r[3]), 32'd1);
        access("rd_hit_0123", 1'b0, 16'h0123, 16'h0000, 0, 16'h0000, 1'b1, 16'hBEEF);
        access("wr_hit_0123", 1'b1, 16'h0123, 16'h1234, 1, 16'h0000, 1'b1, 16'h0000);
        access("rd_after_wr", 1'b0, 16'h0123, 16'h0000, 0, 16'h0000, 1'b1, 16'h1234);
        access("wr_miss_0045", 1'b1, 16'h0045, 16'hAAAA, 0, 16'h0000, 1'b0, 16'h0000);
        chk("valid5_clear", 32'(dut.valid_r[5]), 32'd0);
        access("rd_miss_0045", 1'b0, 16'h0045, 16'h0000, 0, 16'h5555, 1'b0, 16'h5555);
        access("conflict_1123", 1'b0, 16'h1123, 16'h0000, 1, 16'h7777, 1'b0, 16'h7777);
        access("evicted_0123", 1'b0, 16'h0123, 16'h0000, 0, 16'h1234, 1'b0, 16'h1234);
        access("rd_miss_ffff", 1'b0, 16'hFFFF, 16'h0000, 0, 16'hCAFE, 1'b0, 16'hCAFE);
        access("rd_hit_ffff", 1'b0, 16'hFFFF, 16'h0000, 0, 16'h0000, 1'b1, 16'hCAFE);
        access("rd_miss_0000", 1'b0, 16'h0000, 16'h0000, 3, 16'h0F0F, 1'b0, 16'h0F0F);
        access("rd_hit_0000", 1'b0, 16'h0000, 16'h0000, 0, 16'h0000, 1'b1, 16'h0F0F);

`ifdef CACHE_CTRL_STATS_EN
        chk("stats:hits", 32'(hit_count), 32'd5);
        chk("stats:misses", 32'(miss_count), 32'd7);
        stats_clr = 1'b1;
        tick;
        stats_clr = 1'b0;
        chk("stats:clr", {hit_count, miss_count}, 32'd0);
`endif

        // Stray mem_ack while idle must be ignored.
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        chk("idle_ack:quiet", {30'd0, mem_req, cpu_ack}, 32'd0);
        tick;
        chk("idle_ack:still_idle", {30'd0, mem_req, cpu_ack}, 32'd0);

        // Abandon a refill with reset before memory answers.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0200;
        tick;
        tick;
        chk("rst_mid:in_refill", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick;
        chk("rst_mid:quiet", {30'd0, mem_req, cpu_ack}, 32'd0);
        chk("rst_mid:valid", 32'(dut.valid_r), 32'd0);
`ifdef CACHE_CTRL_STATS_EN
        chk("rst_mid:counts", {hit_count, miss_count}, 32'd0);
`endif
        reset   = 1'b0;
        cpu_req = 1'b0;
        tick;
        access("post_rst_0123", 1'b0, 16'h0123, 16'h0000, 0, 16'h4321, 1'b0, 16'h4321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
